// File: rtl/arb_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state encoding, requester count, index width and index rotation.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } state_e;

  // Next requester index, wrapping 3 -> 0.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// 2-to-4 one-hot decoder for the arbiter grant.
// Ports:
//   idx_i     winning/owner index
//   en_i      decode enable; low forces an all-zero output
//   onehot_o  one-hot grant vector
module grant_decoder
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0]   idx_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a mandatory dead cycle between
// owners. Optional hold-time limit compiled in with `define ARB_TIMEOUT_EN.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         global enable; low releases the owner and blocks new grants
//   req[3:0]   level requests, held while ownership is wanted
//   gnt[3:0]   one-hot grant, zero when no owner
//   gnt_idx    current owner index, holds last owner while gnt is zero
//   gnt_valid  high while gnt is non-zero
//   timeout    one-cycle pulse on a forced release (0 without ARB_TIMEOUT_EN)
// Parameters:
//   HOLD_MAX   max consecutive grant cycles per owner (1..255), timeout build only
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             expire;

  // Search order ptr, ptr+1, ptr+2, ptr+3. Iterating from the farthest offset
  // down lets the nearest requesting offset overwrite and win.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req[ptr_q + IDX_W'(i - 1)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE, RELEASE: begin
        if (en && win_found) begin
          state_d = GRANT;
          idx_d   = win_idx;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!en || !req[idx_q] || expire) begin
          state_d = RELEASE;
          ptr_d   = next_idx(idx_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Counter reads HOLD_MAX-1 during the HOLD_MAX-th grant cycle.
  assign expire = (state_q == GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    if (state_q != GRANT) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CNT_W'(HOLD_MAX)) cnt_d = cnt_q + 1'b1;
      // Only a release caused purely by expiry counts as forced.
      timeout_d = expire && en && req[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  grant_decoder u_dec (
    .idx_i    (idx_q),
    .en_i     (state_q == GRANT),
    .onehot_o (gnt)
  );

  assign gnt_idx   = idx_q;
  assign gnt_valid = (state_q == GRANT);

endmodule
